// File: rtl/ucsbece154a_dmem_mmio.sv
// Data-side memory for the single-cycle core: word RAM plus an MMIO page holding a
// free-running cycle counter, an LED register and a byte TX FIFO with a valid/ready drain.
module ucsbece154a_dmem_mmio #(
  parameter int unsigned RAM_WORDS = 64,
  parameter int unsigned TX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  logic [31:0] a_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd_o,
  output logic [7:0]  led_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        err_o
);
  localparam int unsigned RamAw = $clog2(RAM_WORDS);
  localparam int unsigned TxAw  = $clog2(TX_DEPTH);
  localparam int unsigned CntW  = TxAw + 1;

  logic [31:0]     ram [RAM_WORDS];
  logic [7:0]      fifo [TX_DEPTH];
  logic [31:0]     cycle_q;
  logic [7:0]      led_q;
  logic [TxAw-1:0] rptr_q;
  logic [TxAw-1:0] wptr_q;
  logic [CntW-1:0] count_q;
  logic            err_q;

  logic             is_ram;
  logic             is_mmio;
  logic [1:0]       sel;
  logic [RamAw-1:0] ram_idx;
  logic             wr_ram;
  logic             wr_cycle;
  logic             wr_led;
  logic             push_req;
  logic             wr_status;
  logic             wr_unmapped;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push;
  logic             drop;
  logic             err_set;
  logic [31:0]      status;

  assign is_ram  = (a_i[31:16] == 16'h0000);
  assign is_mmio = (a_i[31:4] == 28'hFFFF000);
  assign sel     = a_i[3:2];
  assign ram_idx = a_i[RamAw+1:2];

  // Byte offset and RAM alias bits take no part in decode.
  logic unused_addr;
  assign unused_addr = ^{a_i[15:RamAw+2], a_i[1:0]};

  assign wr_ram      = we_i & is_ram;
  assign wr_cycle    = we_i & is_mmio & (sel == 2'd0);
  assign wr_led      = we_i & is_mmio & (sel == 2'd1);
  assign push_req    = we_i & is_mmio & (sel == 2'd2);
  assign wr_status   = we_i & is_mmio & (sel == 2'd3);
  assign wr_unmapped = we_i & ~is_ram & ~is_mmio;

  assign full  = (count_q == CntW'(TX_DEPTH));
  assign empty = (count_q == '0);
  assign pop   = ~empty & tx_ready_i;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push  = push_req & (~full | pop);
  assign drop  = push_req & full & ~pop;

  assign err_set = drop | wr_unmapped;
  assign status  = {23'b0, err_q, 6'(count_q), empty, full};

  always_comb begin
    rd_o = 32'h0;
    if (is_ram) begin
      rd_o = ram[ram_idx];
    end else if (is_mmio) begin
      case (sel)
        2'd0:    rd_o = cycle_q;
        2'd1:    rd_o = {24'h0, led_q};
        2'd2:    rd_o = 32'h0;
        default: rd_o = status;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q <= '0;
      led_q   <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cycle_q <= wr_cycle ? wd_i : cycle_q + 32'd1;
      if (wr_led) led_q <= wd_i[7:0];
      if (pop) rptr_q <= rptr_q + TxAw'(1);
      if (push) wptr_q <= wptr_q + TxAw'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      if (err_set) begin
        err_q <= 1'b1;
      end else if (wr_status) begin
        err_q <= 1'b0;
      end
    end
  end

  // Storage arrays are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ram) ram[ram_idx] <= wd_i;
    if (push) fifo[wptr_q] <= wd_i[7:0];
  end

  assign led_o      = led_q;
  assign err_o      = err_q;
  assign tx_valid_o = ~empty;
  assign tx_data_o  = fifo[rptr_q];

endmodule
